// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encodings,
// instruction field split and the NOP opcode used as the IR reset value.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_EXEC  = 2'd2,
    FS_FAULT = 2'd3
  } fs_state_e;

  // Opcode occupies the top OP_WIDTH bits of the instruction word,
  // the immediate takes everything below it.
  localparam int unsigned OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_NOP = 4'h0;

endpackage

// File: rtl/fetch_unit_if.sv
// Program ROM request/acknowledge bus between the fetch stage and ROM.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_req;
  logic                  rom_ack;
  logic [DATA_WIDTH-1:0] rom_data;

  modport master (
    output rom_addr,
    output rom_req,
    input  rom_ack,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  rom_req,
    output rom_ack,
    output rom_data
  );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register: async reset to zero, synchronous load,
// and increment that wraps modulo 2^ADDR_WIDTH.
module pc_counter #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_data,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] q
);

  // Load has priority over increment; otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (inc) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches instruction words from
// program ROM over req/ack, latches them into the IR for the decoder and
// applies jump loads from execute. Free-run, single-step, ROM timeout.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           run,
  input  logic                           step,
  fetch_unit_if.master                   rom,
  output logic [OP_WIDTH-1:0]            op_out,
  output logic [DATA_WIDTH-OP_WIDTH-1:0] im_out,
  output logic                           instr_valid,
  input  logic                           pc_load,
  input  logic [ADDR_WIDTH-1:0]          pc_load_data,
  output logic [ADDR_WIDTH-1:0]          pc_out,
  output logic                           halted,
  output logic                           fault
);

  localparam int unsigned CNT_WIDTH = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ACK_TIMEOUT - 1);

  fs_state_e             state, state_nxt;
  logic [DATA_WIDTH-1:0] ir;
  logic [CNT_WIDTH-1:0]  wait_cnt, wait_cnt_nxt;
  logic                  req;
  logic                  ir_load;
  logic                  pc_ld;
  logic                  pc_inc;

  // State and ROM wait counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FS_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state and per-state outputs; rom_ack only matters in FETCH,
  // pc_load only in EXEC. The timeout fires on the ACK_TIMEOUT-th wait cycle.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    req          = 1'b0;
    ir_load      = 1'b0;
    instr_valid  = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    pc_ld        = 1'b0;
    pc_inc       = 1'b0;
    unique case (state)
      FS_IDLE: begin
        halted = 1'b1;
        if (run || step) begin
          state_nxt = FS_FETCH;
        end
      end
      FS_FETCH: begin
        req = 1'b1;
        if (rom.rom_ack) begin
          ir_load   = 1'b1;
          state_nxt = FS_EXEC;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = FS_FAULT;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      FS_EXEC: begin
        instr_valid = 1'b1;
        pc_ld       = pc_load;
        pc_inc      = !pc_load;
        state_nxt   = run ? FS_FETCH : FS_IDLE;
      end
      FS_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_nxt = FS_IDLE;
      end
    endcase
  end

  // Instruction register: changes only on an accepted ROM word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= {OP_NOP, {(DATA_WIDTH-OP_WIDTH){1'b0}}};
    end else if (ir_load) begin
      ir <= rom.rom_data;
    end
  end

  pc_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_ld),
    .load_data(pc_load_data),
    .inc      (pc_inc),
    .q        (pc_out)
  );

  assign rom.rom_req  = req;
  assign rom.rom_addr = pc_out;
  assign op_out       = ir[DATA_WIDTH-1 -: OP_WIDTH];
  assign im_out       = ir[DATA_WIDTH-OP_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: instruction-level reference model
// with randomized ROM contents, ack delays and jumps.
module tb_fetch_unit;

  logic       clk;
  logic       reset;
  logic       run;
  logic       step;
  logic [3:0] op_out;
  logic [3:0] im_out;
  logic       instr_valid;
  logic       pc_load;
  logic [3:0] pc_load_data;
  logic [3:0] pc_out;
  logic       halted;
  logic       fault;

  fetch_unit_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bif ();

  fetch_unit #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (8),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .rom         (bif),
    .op_out      (op_out),
    .im_out      (im_out),
    .instr_valid (instr_valid),
    .pc_load     (pc_load),
    .pc_load_data(pc_load_data),
    .pc_out      (pc_out),
    .halted      (halted),
    .fault       (fault)
  );

  logic [7:0] rom_mem [16];
  assign bif.rom_data = rom_mem[bif.rom_addr];

  // Reference model: architectural PC and last fetched instruction.
  logic [3:0] exp_pc;
  logic [7:0] exp_ir;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Quiescent IDLE: nothing requested, IR and PC hold.
  task automatic chk_idle(input string tag);
    chk({tag, "_halted"}, 32'(halted), 32'd1);
    chk({tag, "_req"},    32'(bif.rom_req), 32'd0);
    chk({tag, "_ivalid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_fault"},  32'(fault), 32'd0);
    chk({tag, "_pc"},     32'(pc_out), 32'(exp_pc));
    chk({tag, "_op"},     32'(op_out), 32'(exp_ir[7:4]));
    chk({tag, "_im"},     32'(im_out), 32'(exp_ir[3:0]));
  endtask

  // One instruction, entered at the negedge of its first FETCH cycle.
  // ROM answers after `delay` wait cycles; EXEC optionally jumps; run is
  // set to keep_run for the EXEC-exit decision.
  task automatic fetch_exec(input int unsigned delay, input bit jump,
                            input logic [3:0] tgt, input bit keep_run);
    for (int unsigned k = 0; k <= delay; k++) begin
      chk("f_req",    32'(bif.rom_req), 32'd1);
      chk("f_addr",   32'(bif.rom_addr), 32'(exp_pc));
      chk("f_ivalid", 32'(instr_valid), 32'd0);
      chk("f_halted", 32'(halted), 32'd0);
      chk("f_op_hold", 32'(op_out), 32'(exp_ir[7:4]));
      bif.rom_ack  = (k == delay);
      pc_load      = 1'($urandom_range(0, 1));
      pc_load_data = 4'($urandom);
      @(negedge clk);
    end
    exp_ir = rom_mem[exp_pc];
    chk("x_ivalid", 32'(instr_valid), 32'd1);
    chk("x_req",    32'(bif.rom_req), 32'd0);
    chk("x_op",     32'(op_out), 32'(exp_ir[7:4]));
    chk("x_im",     32'(im_out), 32'(exp_ir[3:0]));
    chk("x_pc",     32'(pc_out), 32'(exp_pc));
    bif.rom_ack  = 1'($urandom_range(0, 1));
    pc_load      = jump;
    pc_load_data = tgt;
    run          = keep_run;
    @(negedge clk);
    pc_load     = 1'b0;
    bif.rom_ack = 1'b0;
    exp_pc      = jump ? tgt : exp_pc + 4'd1;
  endtask

  initial begin
    reset        = 1'b1;
    run          = 1'b0;
    step         = 1'b0;
    bif.rom_ack  = 1'b0;
    pc_load      = 1'b0;
    pc_load_data = '0;
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'($urandom);
    rom_mem[0]  = 8'h31;
    rom_mem[1]  = 8'h52;
    rom_mem[2]  = 8'hB0;
    rom_mem[15] = 8'h00;
    exp_pc = '0;
    exp_ir = '0;

    repeat (2) @(negedge clk);
    chk_idle("rst");
    reset = 1'b0;
    @(negedge clk);
    chk_idle("post_rst");

    // Back-to-back zero-wait fetches from address 0.
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) fetch_exec(0, 1'b0, 4'h0, 1'b1);

    // Sequential through address 15, then wrap.
    for (int i = 0; i < 13; i++) fetch_exec($urandom_range(0, 3), 1'b0, 4'h0, 1'b1);
    chk("wrap_addr", 32'(bif.rom_addr), 32'd0);

    // Jump taken at address 4.
    for (int i = 0; i < 4; i++) fetch_exec($urandom_range(0, 2), 1'b0, 4'h0, 1'b1);
    fetch_exec(0, 1'b1, 4'h9, 1'b1);
    chk("jump_addr", 32'(bif.rom_addr), 32'd9);

    // Random instruction stream.
    for (int i = 0; i < 40; i++)
      fetch_exec($urandom_range(0, 4), ($urandom_range(0, 3) == 0), 4'($urandom), 1'b1);

    // Stop at PC=3, then single-step one instruction with a 2-cycle wait.
    fetch_exec(0, 1'b1, 4'h3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_idle("idle");
      bif.rom_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bif.rom_ack = 1'b0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    fetch_exec(2, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_idle("after_step");
      @(negedge clk);
    end
    chk("step_pc", 32'(pc_out), 32'd4);

    // ROM never answers: fault after ACK_TIMEOUT fetch cycles.
    run = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 15; k++) begin
      chk("to_req",   32'(bif.rom_req), 32'd1);
      chk("to_fault", 32'(fault), 32'd0);
      @(negedge clk);
    end
    chk("flt_fault",  32'(fault), 32'd1);
    chk("flt_req",    32'(bif.rom_req), 32'd0);
    chk("flt_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 8; i++) begin
      run          = 1'($urandom_range(0, 1));
      step         = 1'($urandom_range(0, 1));
      bif.rom_ack  = 1'($urandom_range(0, 1));
      pc_load      = 1'($urandom_range(0, 1));
      pc_load_data = 4'($urandom);
      @(negedge clk);
      chk("flt_sticky", 32'(fault), 32'd1);
      chk("flt_req2",   32'(bif.rom_req), 32'd0);
      chk("flt_ivalid", 32'(instr_valid), 32'd0);
      chk("flt_pc",     32'(pc_out), 32'(exp_pc));
      chk("flt_op",     32'(op_out), 32'(exp_ir[7:4]));
    end
    run = 1'b0; step = 1'b0; bif.rom_ack = 1'b0; pc_load = 1'b0;
    reset = 1'b1;
    #1;
    exp_pc = '0;
    exp_ir = '0;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_pc",    32'(pc_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("clr");

    // Asynchronous reset in the middle of a fetch at PC=6.
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) fetch_exec($urandom_range(0, 1), 1'b0, 4'h0, 1'b1);
    chk("mid_req",  32'(bif.rom_req), 32'd1);
    chk("mid_addr", 32'(bif.rom_addr), 32'd6);
    #2;
    reset = 1'b1;
    #1;
    exp_pc = '0;
    exp_ir = '0;
    chk("ar_req",    32'(bif.rom_req), 32'd0);
    chk("ar_pc",     32'(pc_out), 32'd0);
    chk("ar_op",     32'(op_out), 32'd0);
    chk("ar_im",     32'(im_out), 32'd0);
    chk("ar_ivalid", 32'(instr_valid), 32'd0);
    run = 1'b0;
    bif.rom_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("late_ack");
    end
    bif.rom_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
